// File: rtl/stream_pkg.sv
// Shared types and default sizing for the block-order restoring stream path.
package stream_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_BLOCK = 8;
  localparam int unsigned IDX_W     = $clog2(DEF_BLOCK);
  localparam int unsigned CNT_W     = $clog2(DEF_BLOCK) + 1;

endpackage

// File: rtl/stream_bank.sv
// One half of the ping-pong buffer: word storage, fill count and EMPTY/FULL state.
module stream_bank
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(BLOCK)-1:0]   wr_idx,
  input  logic                       we,
  input  logic                       close,
  input  logic [$clog2(BLOCK)-1:0]   rd_idx,
  input  logic                       free,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(BLOCK):0]     count,
  output logic                       full
);

  localparam int unsigned CW = $clog2(BLOCK) + 1;

  logic [WIDTH-1:0] mem [BLOCK];
  bank_state_e      state_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // close and free never hit the same bank in one cycle: writes need EMPTY, reads need FULL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else if (close) begin
      state_q <= FULL;
      count_q <= CW'(wr_idx) + CW'(1);
    end else if (free) begin
      state_q <= EMPTY;
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = count_q;
  assign full    = (state_q == FULL);

endmodule

// File: rtl/stream_uninverse.sv
// Restores original word order within blocks that arrive reversed, using two ping-pong banks.
module stream_uninverse
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned   IW       = $clog2(BLOCK);
  localparam int unsigned   CW       = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK - 1);

  logic             wbank, rbank;
  logic [IW-1:0]    widx, rpos, ridx;
  logic [CW-1:0]    rd_count;
  logic [1:0]       full;
  logic [WIDTH-1:0] bank_data  [2];
  logic [CW-1:0]    bank_count [2];
  logic             accept, close_blk, take, drain_done;

  assign in_ready   = ~full[wbank];
  assign out_valid  = full[rbank];
  assign accept     = in_valid & in_ready;
  assign close_blk  = accept & (in_last | (widx == LAST_IDX));

  // ridx = count-1 down to 0, derived from an up-counter so it is valid whenever a bank fills
  assign rd_count   = bank_count[rbank];
  assign ridx       = IW'(rd_count - CW'(1) - CW'(rpos));
  assign out_last   = out_valid & (ridx == '0);
  assign take       = out_valid & out_ready;
  assign drain_done = take & out_last;
  assign out_data   = out_valid ? bank_data[rbank] : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    stream_bank #(
      .WIDTH(WIDTH),
      .BLOCK(BLOCK)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_data(in_data),
      .wr_idx (widx),
      .we     (accept & (wbank == 1'(b))),
      .close  (close_blk & (wbank == 1'(b))),
      .rd_idx (ridx),
      .free   (drain_done & (rbank == 1'(b))),
      .rd_data(bank_data[b]),
      .count  (bank_count[b]),
      .full   (full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      widx  <= '0;
      rbank <= 1'b0;
      rpos  <= '0;
    end else begin
      if (accept) begin
        if (close_blk) begin
          widx  <= '0;
          wbank <= ~wbank;
        end else begin
          widx <= widx + IW'(1);
        end
      end
      if (take) begin
        if (out_last) begin
          rpos  <= '0;
          rbank <= ~rbank;
        end else begin
          rpos <= rpos + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_uninverse.sv
// Bench for stream_uninverse (BLOCK = 4): vector table, directed sequences, random traffic vs a block-queue model.
module tb_stream_uninverse;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BLOCK = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  stream_uninverse #(
    .WIDTH(WIDTH),
    .BLOCK(BLOCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: completed blocks queued in arrival order, emitted back to front
  typedef struct {
    logic [WIDTH-1:0] w [BLOCK];
    int unsigned      n;
  } blk_t;

  blk_t             full_q [$];
  blk_t             cur;
  int unsigned      opos;
  logic [WIDTH-1:0] got [$];

  function automatic logic m_ready();
    return full_q.size() < 2;
  endfunction

  function automatic logic m_valid();
    return full_q.size() > 0;
  endfunction

  function automatic logic [WIDTH-1:0] m_data();
    if (full_q.size() == 0) return '0;
    return full_q[0].w[full_q[0].n - 1 - opos];
  endfunction

  function automatic logic m_last();
    if (full_q.size() == 0) return 1'b0;
    return opos == full_q[0].n - 1;
  endfunction

  task automatic model_update();
    logic acc, tk;
    if (rst) begin
      full_q.delete();
      cur.n = 0;
      opos  = 0;
      return;
    end
    acc = in_valid && m_ready();
    tk  = m_valid() && out_ready;
    if (tk) begin
      if (opos == full_q[0].n - 1) begin
        void'(full_q.pop_front());
        opos = 0;
      end else begin
        opos++;
      end
    end
    if (acc) begin
      cur.w[cur.n] = in_data;
      cur.n++;
      if (cur.n == BLOCK || in_last) begin
        full_q.push_back(cur);
        cur.n = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called in the low phase with inputs set: check outputs, cross one rising edge, return at the next low phase
  task automatic step();
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid()});
    chk("out_data", out_data, m_data());
    chk("out_last", {31'b0, out_last}, {31'b0, m_last()});
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_got(input string name, input int unsigned n);
    chk({name, "_count"}, got.size(), n);
    for (int unsigned i = 0; i < n && i < got.size(); i++) chk(name, got[i], i + 1);
  endtask

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v, l, r;
    logic             er, ev;
    logic [WIDTH-1:0] ed;
    logic             el;
  } vec_t;

  function automatic vec_t mk(input logic [WIDTH-1:0] d, input logic v, input logic l,
                              input logic r, input logic er, input logic ev,
                              input logic [WIDTH-1:0] ed, input logic el);
    vec_t x;
    x.d = d; x.v = v; x.l = l; x.r = r;
    x.er = er; x.ev = ev; x.ed = ed; x.el = el;
    return x;
  endfunction

  vec_t             tbl [17];
  logic [WIDTH-1:0] bp_words [8];

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    cur.n = 0; opos = 0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;

    // Outputs checked before each edge, then the row's inputs are applied at that edge
    tbl[0]  = mk(4,  1, 0, 1, 1, 0, 0,  0);
    tbl[1]  = mk(3,  1, 0, 1, 1, 0, 0,  0);
    tbl[2]  = mk(2,  1, 0, 1, 1, 0, 0,  0);
    tbl[3]  = mk(1,  1, 0, 1, 1, 0, 0,  0);
    tbl[4]  = mk(0,  0, 0, 1, 1, 1, 1,  0);
    tbl[5]  = mk(0,  0, 1, 1, 1, 1, 2,  0);
    tbl[6]  = mk(0,  0, 0, 1, 1, 1, 3,  0);
    tbl[7]  = mk(0,  0, 0, 1, 1, 1, 4,  1);
    tbl[8]  = mk(42, 1, 1, 1, 1, 0, 0,  0);
    tbl[9]  = mk(0,  0, 0, 1, 1, 1, 42, 1);
    tbl[10] = mk(3,  1, 0, 1, 1, 0, 0,  0);
    tbl[11] = mk(2,  1, 0, 1, 1, 0, 0,  0);
    tbl[12] = mk(1,  1, 1, 1, 1, 0, 0,  0);
    tbl[13] = mk(0,  0, 0, 1, 1, 1, 1,  0);
    tbl[14] = mk(0,  0, 0, 1, 1, 1, 2,  0);
    tbl[15] = mk(0,  0, 0, 1, 1, 1, 3,  1);
    tbl[16] = mk(0,  0, 0, 1, 1, 0, 0,  0);
    for (int unsigned i = 0; i < 17; i++) begin
      in_data = tbl[i].d; in_valid = tbl[i].v; in_last = tbl[i].l; out_ready = tbl[i].r;
      chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, tbl[i].er});
      chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, tbl[i].ev});
      chk("tbl_out_data", out_data, tbl[i].ed);
      chk("tbl_out_last", {31'b0, out_last}, {31'b0, tbl[i].el});
      step();
    end

    // Streaming: three reversed blocks back to back
    got.delete();
    in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    for (int unsigned blk = 0; blk < 3; blk++) begin
      for (int unsigned k = 0; k < BLOCK; k++) begin
        in_data = blk * BLOCK + BLOCK - k;
        chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
        step();
      end
    end
    in_valid = 1'b0;
    for (int unsigned k = 0; k < 8; k++) step();
    check_got("stream", 12);

    // Backpressure: two full blocks stall the sender, ninth word is held
    got.delete();
    bp_words[0] = 4; bp_words[1] = 3; bp_words[2] = 2; bp_words[3] = 1;
    bp_words[4] = 8; bp_words[5] = 7; bp_words[6] = 6; bp_words[7] = 5;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      in_data = bp_words[k];
      step();
    end
    in_data = 12;
    for (int unsigned k = 0; k < 3; k++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_data", out_data, 32'd1);
      step();
    end
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 20 && !m_ready(); k++) step();
    chk("bp_resume", {31'b0, in_ready}, 32'd1);
    step();
    in_data = 11; step();
    in_data = 10; step();
    in_data = 9;  step();
    in_valid = 1'b0;
    for (int unsigned k = 0; k < 12; k++) step();
    check_got("bp", 12);

    // Reset in the middle of a block drops buffered words
    in_valid = 1'b1;
    in_data = 4; step();
    in_data = 3; step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    got.delete();
    in_valid = 1'b1;
    for (int unsigned k = 0; k < BLOCK; k++) begin
      in_data = BLOCK - k;
      step();
    end
    in_valid = 1'b0;
    for (int unsigned k = 0; k < 6; k++) step();
    check_got("rst_block", 4);

    // Random traffic against the model
    for (int unsigned k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_uninverse.md
# stream_uninverse

- Receive-side counterpart of the stream inverter.
- Accepts a valid/ready stream whose blocks of up to BLOCK words arrive in reversed order, restores original order within each block, and re-emits them on a valid/ready output.
- Sits at the consumer end of the inverter link; inverter followed by this block is an identity on the word sequence.
- Ping-pong double buffer: one bank fills while the other drains, giving one word per cycle of sustained throughput.

## Interface

Parameters:
- WIDTH, 32, data word width.
- BLOCK, 8, words per full block; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  WIDTH  input word.
- in_valid  in  1  input word present.
- in_last  in  1  marks final word of a short (partial) block; ignored unless in_valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  WIDTH  restored word.
- out_valid  out  1  out_data is valid.
- out_last  out  1  final word of the current output block.
- out_ready  in  1  downstream accepts this cycle.

## Operation

- Two banks, each BLOCK×WIDTH storage plus a fill count (0..BLOCK) and a state: EMPTY or FULL.
- Write side:
  - Bank wbank, index widx.
  - in_ready = (state[wbank] == EMPTY).
  - On in_valid && in_ready: store at widx, widx++.
  - Bank closes when widx == BLOCK-1, or when in_last is set. On close: count = widx+1, state becomes FULL, wbank toggles, widx = 0.
- Read side:
  - Bank rbank, index ridx.
  - out_valid = (state[rbank] == FULL).
  - ridx starts at count-1 and steps down to 0, so the last-received word goes out first.
  - out_last = out_valid && ridx == 0.
  - On out_valid && out_ready at ridx == 0: state becomes EMPTY and rbank toggles.
- out_data = mem[rbank][ridx] when out_valid, else 0.
- in_last on the first word gives a block of count 1: one output word with out_last = 1.
- Write and read never target the same bank in the same cycle; a bank close and a bank release on opposite banks in the same cycle are both honoured.
- Backpressure: with both banks FULL, in_ready = 0 until rbank drains.

## Timing

Reset (rst high at a clock edge), next cycle:
- in_ready = 1; out_valid = 0; out_last = 0; out_data = 0.
- Both banks EMPTY, wbank = rbank = 0, widx = 0.
- Reset mid-block discards all buffered words without emitting them.

Latency and throughput:
- The first output word of a block is valid the cycle after the edge that accepted that block's last input word.
- in_ready and out_valid depend only on registered state, with no combinational path from in_valid or out_ready.
- Steady state with out_ready held high: one word per cycle in and out; in_ready never deasserts.
- Block latency is count cycles.

Handshake rules:
- out_data and out_last are held stable while out_valid && !out_ready.
- Input words offered while in_ready = 0 are not consumed; the sender holds them.

## Structure

- Package stream_pkg holds:
  - bank_state_e {EMPTY, FULL};
  - default WIDTH and BLOCK constants;
  - index width localparam $clog2(BLOCK), and count width $clog2(BLOCK)+1.
- Sub-module stream_bank, instantiated twice. Each holds:
  - storage;
  - fill count;
  - state;
  - write port (data, index, we, close);
  - read port (index, release).
- Top level owns wbank, widx, rbank, ridx, and the output muxing.

## Test plan

All scenarios use BLOCK = 4.
- Reset then a full block: inputs 4, 3, 2, 1 at one per cycle with out_ready = 1. Outputs are 1, 2, 3, 4; out_last on 4; first out_valid one cycle after input 1 is accepted.
- Streaming: inputs 4, 3, 2, 1, 8, 7, 6, 5, 12, 11, 10, 9 back-to-back. Outputs are 1..12 in order; in_ready stays high throughout.
- Partial block: inputs 3, 2, 1 with in_last on 1, then a full block 7, 6, 5, 4. Outputs are 1, 2, 3 (out_last on 3), then 4, 5, 6, 7.
- Backpressure: out_ready = 0 while two full blocks are sent. in_ready drops after 8 accepted words, the 9th is held, out_data is stable at 1. Releasing out_ready drains 1..8, then the 9th is accepted.
- Single-word block: input 42 with in_last. Output 42 with out_last = 1 and count 1.
- Reset mid-operation: assert rst after 2 of 4 words. All outputs are at reset values the next cycle; a following block 4, 3, 2, 1 yields 1, 2, 3, 4 with no stale words.
